serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b` one bit per clock, LSB first, with a start/busy/done handshake. It is the sequential counterpart to the team's combinational adder cells. It is used where area matters more than latency, such as multi-cycle datapaths and accumulator down-counters. One full-subtractor cell plus a borrow flip-flop replaces a WIDTH-bit ripple chain.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is ≥ 1.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  minuend; sampled on the accepted start.
- `b`  input  WIDTH  subtrahend; sampled on the accepted start.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse; `diff`, `borrow_out` and `overflow` are valid from this cycle.
- `diff`  output  WIDTH  `a - b` modulo 2^WIDTH.
- `borrow_out`  output  1  final borrow; equals 1 iff a < b (unsigned).
- `overflow`  output  1  signed overflow flag; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with `start=1`:
  - latch `a` into shift register A and `b` into shift register B;
  - clear the borrow flip-flop and the bit counter;
  - go to RUN.
- IDLE with `start=0`: stay in IDLE.
- Each RUN cycle, with bin = the borrow flip-flop:
  - d = A[0] ^ B[0] ^ bin;
  - bout = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & bin).
- Each RUN cycle then:
  - shift A and B right by one;
  - shift d into the MSB of the result register;
  - load bout into the borrow flip-flop;
  - increment the counter.
- After the WIDTH-th bit, go to DONE. The counter needs $clog2(WIDTH+1) bits.
- DONE lasts exactly one cycle (`done=1`), then the FSM returns to IDLE.
- `diff`, `borrow_out` and `overflow` hold their values until the next accepted start.
- `start` is ignored in RUN and DONE; no queueing. `start` held high continuously yields a back-to-back operation every WIDTH+2 cycles.
- `a` and `b` may change freely after the accept cycle.
- `diff` is not valid mid-operation. Consumers qualify it with `done` or with `busy=0`.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `diff=0`, `borrow_out=0`, `overflow=0`. Shift registers and counter are also cleared.
- `rst` during RUN or DONE aborts the operation. The next cycle is IDLE with all outputs at reset values, and no `done` pulse is produced.
- `rst` has priority over `start` in the same cycle.
- With `start` sampled high at edge 0:
  - `busy=1` from edge 0 through edge WIDTH (WIDTH cycles);
  - `done=1` for one cycle after edge WIDTH;
  - IDLE after edge WIDTH+1.
- Latency from start to done is WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- WIDTH=1: exactly one RUN cycle; behaviour is otherwise identical.

## Configuration
- Macro `SERIAL_SUB_OVF_EN`.
- Defined:
  - the `overflow` port exists;
  - on the accepted start, the block captures a[WIDTH-1] and b[WIDTH-1];
  - at the transition into DONE, it sets overflow = (a_msb != b_msb) && (d_msb != a_msb), where d_msb is the final result MSB;
  - the flag holds with the result.
- Undefined: no `overflow` port, no MSB capture registers. All other behaviour is unchanged.

## Structure
- Package `adder_pkg` holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the default WIDTH constant.
- One sub-module, `full_subtractor`: combinational, with inputs a, b, bin and outputs d, bout, implementing the equations above.
- `serial_subtractor` instantiates `full_subtractor` once and owns all state.

## Test plan
- WIDTH=8, a=100, b=37, start for 1 cycle:
  - `done` 9 cycles after start;
  - `diff=63`, `borrow_out=0`, `busy` high for exactly 8 cycles.
- a=5, b=9 -> `diff=252` (0xFC), `borrow_out=1`. With the macro: `overflow=0`.
- Macro on: a=0x80, b=0x01 -> `diff=0x7F`, `borrow_out=0`, `overflow=1`. Also a=b=0xAA -> `diff=0`, `borrow_out=0`, `overflow=0`.
- `start` pulsed with a=3, b=1, then pulsed again 2 cycles later with a=9, b=9:
  - the second pulse is ignored;
  - a single `done` pulse with `diff=2`.
- `rst` asserted at RUN cycle 4:
  - next cycle IDLE, all outputs 0, no `done` pulse;
  - a following start with a=200, b=55 completes normally with `diff=145`.
- WIDTH=1 exhaustive, all four a/b pairs:
  - 0-1 -> `diff=1`, `borrow_out=1`;
  - 1-0 -> `diff=1`, `borrow_out=0`;
  - each pair: `done` 2 cycles after start.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared types and constants for the bit-serial arithmetic cells.
//   sub_state_e : FSM state encoding (IDLE, RUN, DONE)
//   DEF_WIDTH   : default operand width
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_e;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit combinational subtractor cell, d = a - b - bin.
//   a, b  : operand bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b,
// one bit per clock, LSB first, start/busy/done handshake.
//   clk, rst    : clock, synchronous active-high reset
//   start       : request, sampled only in IDLE
//   a, b        : minuend / subtrahend, captured on the accepted start
//   busy        : high while bits are being processed (WIDTH cycles)
//   done        : one-cycle pulse; results valid from this cycle on
//   diff        : a - b modulo 2^WIDTH, held until the next accepted start
//   borrow_out  : final borrow (a < b unsigned)
//   overflow    : signed overflow, only when SERIAL_SUB_OVF_EN is defined
module serial_subtractor
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             overflow,
`endif
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH + 1);

  sub_state_e       state;
  logic [WIDTH-1:0] sa, sb, res, res_nxt;
  logic [CW-1:0]    cnt;
  logic             bflop;
  logic             d_bit, b_bit;
  logic             last;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb, b_msb;
`endif

  full_subtractor u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (bflop),
    .d    (d_bit),
    .bout (b_bit)
  );

  // New bit enters at the MSB so that after WIDTH shifts the LSB lands at bit 0.
  generate
    if (WIDTH == 1) begin : g_res1
      assign res_nxt = d_bit;
    end else begin : g_resn
      assign res_nxt = {d_bit, res[WIDTH-1:1]};
    end
  endgenerate

  assign last       = (cnt == CW'(WIDTH - 1));
  assign diff       = res;
  assign borrow_out = bflop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      cnt   <= '0;
      bflop <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            bflop <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            overflow <= 1'b0;
`endif
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          res   <= res_nxt;
          bflop <= b_bit;
          cnt   <= cnt + CW'(1);
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            // d_bit is the final result MSB on the last RUN cycle.
            overflow <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor at WIDTH=8 and
// WIDTH=1, with a reference model computed from plain integer arithmetic.
module tb_serial_subtractor;
  typedef struct {
    int     a;
    int     b;
    int     diff;
    int     bo;
    int     ovf;
    longint due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // WIDTH=8 instance
  logic       rst8 = 1'b1, start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       busy8, done8, bo8;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8;
`endif
  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8),
`ifdef SERIAL_SUB_OVF_EN
    .overflow(ovf8),
`endif
    .borrow_out(bo8)
  );

  // WIDTH=1 instance
  logic       rst1 = 1'b1, start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, diff1;
  logic       busy1, done1, bo1;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf1;
`endif
  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1),
`ifdef SERIAL_SUB_OVF_EN
    .overflow(ovf1),
`endif
    .borrow_out(bo1)
  );

  exp_t q8[$];
  exp_t q1[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: unsigned modular difference, unsigned compare for borrow,
  // signed range test for overflow.
  function automatic exp_t model(input int w, input int a, input int b, input longint due);
    exp_t e;
    int m, sa, sb, sd;
    m = 1 << w;
    e.a = a; e.b = b; e.due = due;
    e.diff = ((a - b) % m + m) % m;
    e.bo = (a < b) ? 1 : 0;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sd = sa - sb;
    e.ovf = (sd < -(m / 2) || sd > m / 2 - 1) ? 1 : 0;
    return e;
  endfunction

  // Monitors: pop and compare whenever a done pulse is presented.
  int bcnt8 = 0, bcnt1 = 0;
  always @(negedge clk) begin
    if (rst8) bcnt8 = 0;
    else begin
      if (busy8) bcnt8++;
      if (done8) begin
        if (q8.size() == 0) chk("w8 unexpected done", 1, 0);
        else begin
          exp_t e;
          e = q8.pop_front();
          chk($sformatf("w8 diff %0d-%0d", e.a, e.b), diff8, e.diff);
          chk($sformatf("w8 borrow %0d-%0d", e.a, e.b), bo8, e.bo);
`ifdef SERIAL_SUB_OVF_EN
          chk($sformatf("w8 overflow %0d-%0d", e.a, e.b), ovf8, e.ovf);
`endif
          chk("w8 done latency", cyc, e.due);
          chk("w8 busy cycles", bcnt8, 8);
        end
        bcnt8 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst1) bcnt1 = 0;
    else begin
      if (busy1) bcnt1++;
      if (done1) begin
        if (q1.size() == 0) chk("w1 unexpected done", 1, 0);
        else begin
          exp_t e;
          e = q1.pop_front();
          chk($sformatf("w1 diff %0d-%0d", e.a, e.b), diff1, e.diff);
          chk($sformatf("w1 borrow %0d-%0d", e.a, e.b), bo1, e.bo);
`ifdef SERIAL_SUB_OVF_EN
          chk($sformatf("w1 overflow %0d-%0d", e.a, e.b), ovf1, e.ovf);
`endif
          chk("w1 done latency", cyc, e.due);
          chk("w1 busy cycles", bcnt1, 1);
        end
        bcnt1 = 0;
      end
    end
  end

  // Latency contract: start sampled at the edge after issue, done seen WIDTH+1 cycles later.
  task automatic issue8(input int a, input int b);
    @(negedge clk);
    a8 = 8'(a); b8 = 8'(b); start8 = 1'b1;
    q8.push_back(model(8, a, b, cyc + 9));
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 60) begin @(negedge clk); n++; end
    if (q8.size() != 0) begin chk("w8 drain timeout", q8.size(), 0); q8.delete(); end
    @(negedge clk);
  endtask

  task automatic issue1(input int a, input int b);
    @(negedge clk);
    a1 = 1'(a); b1 = 1'(b); start1 = 1'b1;
    q1.push_back(model(1, a, b, cyc + 2));
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~a1;
    b1 = ~b1;
    begin
      int n = 0;
      while (q1.size() != 0 && n < 20) begin @(negedge clk); n++; end
      if (q1.size() != 0) begin chk("w1 drain timeout", q1.size(), 0); q1.delete(); end
    end
    @(negedge clk);
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, " busy"}, busy8, 0);
    chk({tag, " done"}, done8, 0);
    chk({tag, " diff"}, diff8, 0);
    chk({tag, " borrow"}, bo8, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, " overflow"}, ovf8, 0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst8 = 1'b0; rst1 = 1'b0;
    chk_zero8("reset");
    chk("w1 reset diff", diff1, 0);
    chk("w1 reset busy", busy1, 0);

    // Directed cases
    issue8(100, 37);  drain8();
    issue8(5, 9);     drain8();
    issue8(8'h80, 8'h01); drain8();
    issue8(8'hAA, 8'hAA); drain8();
    issue8(0, 255);   drain8();
    issue8(255, 0);   drain8();
    issue8(8'h7F, 8'hFF); drain8();

    // Second start during RUN must be ignored.
    issue8(3, 1);
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    drain8();
    repeat (12) @(negedge clk);

    // Abort in RUN cycle 4: no done, outputs cleared.
    @(negedge clk);
    a8 = 8'd77; b8 = 8'd200; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    chk_zero8("abort");
    repeat (14) @(negedge clk);
    issue8(200, 55); drain8();

    // Held start: back-to-back every WIDTH+2 cycles.
    @(negedge clk);
    a8 = 8'd17; b8 = 8'd250; start8 = 1'b1;
    for (int k = 0; k < 3; k++) q8.push_back(model(8, 17, 250, cyc + 9 + k * 10));
    repeat (30) @(negedge clk);
    start8 = 1'b0;
    drain8();

    // Random
    for (int i = 0; i < 25; i++) begin
      issue8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      drain8();
    end

    // WIDTH=1 exhaustive
    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        issue1(x, y);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
